// File: rtl/amp_pair_sequencer.sv
// Amplitude-pair sequencer: holds a 2**N complex state vector and streams the (i0, i1) pairs
// of a single-qubit gate to the CAU, writing results back in place. Optional macro: SWEEP_STATS_EN.
module amp_pair_sequencer #(
    parameter int N  = 3,
    parameter int W  = 16,
    parameter int TW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ld_en,
    input  logic [N-1:0]  ld_addr,
    input  logic [W-1:0]  ld_re,
    input  logic [W-1:0]  ld_im,
    output logic [W-1:0]  rd_re,
    output logic [W-1:0]  rd_im,
    input  logic          start,
    input  logic [TW-1:0] tgt,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          pair_valid,
    input  logic          pair_ready,
    output logic [W-1:0]  a0_re,
    output logic [W-1:0]  a0_im,
    output logic [W-1:0]  a1_re,
    output logic [W-1:0]  a1_im,
    output logic [N-2:0]  pair_idx,
    input  logic          res_valid,
    output logic          res_ready,
    input  logic [W-1:0]  r0_re,
    input  logic [W-1:0]  r0_im,
    input  logic [W-1:0]  r1_re,
    input  logic [W-1:0]  r1_im,
    output logic [15:0]   stall_cnt
);

    localparam int D = 2**N;
    localparam int P = 2**(N-1);
    localparam logic [N-1:0]  ONE  = N'(1);
    localparam logic [N-1:0]  LAST = N'(P - 1);
    localparam logic [N-1:0]  PCNT = N'(P);
    localparam logic [TW:0]   NQ   = (TW+1)'(N);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t state, state_nxt;
    logic signed [W-1:0] mem_re [D];
    logic signed [W-1:0] mem_im [D];
    logic [N-1:0]  q, r;
    logic [TW-1:0] tgt_r;
    logic [N-1:0]  i0q, i1q, i0r, i1r;
    logic          start_ok, start_bad, xfer, ret;

    // Insert a zero at bit position t: low t bits stay, the rest shift up by one.
    function automatic logic [N-1:0] ins0(input logic [N-1:0] p, input logic [TW-1:0] t);
        logic [N-1:0] lo;
        lo = (ONE << t) - ONE;
        return ((p & ~lo) << 1) | (p & lo);
    endfunction

    assign i0q = ins0({1'b0, q[N-2:0]}, tgt_r);
    assign i1q = i0q | (ONE << tgt_r);
    assign i0r = ins0({1'b0, r[N-2:0]}, tgt_r);
    assign i1r = i0r | (ONE << tgt_r);

    assign start_ok  = (state == IDLE) && start && ({1'b0, tgt} <  NQ);
    assign start_bad = (state == IDLE) && start && ({1'b0, tgt} >= NQ);
    assign xfer      = pair_valid && pair_ready;
    assign ret       = res_valid && res_ready;
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        pair_valid = (state == ISSUE);
        res_ready  = ((state == ISSUE) || (state == DRAIN)) && (r < q);
        a0_re      = '0;
        a0_im      = '0;
        a1_re      = '0;
        a1_im      = '0;
        pair_idx   = '0;
        if (pair_valid) begin
            a0_re    = mem_re[i0q];
            a0_im    = mem_im[i0q];
            a1_re    = mem_re[i1q];
            a1_im    = mem_im[i1q];
            pair_idx = q[N-2:0];
        end
        case (state)
            IDLE:    if (start_ok) state_nxt = ISSUE;
            ISSUE:   if (xfer && (q == LAST)) state_nxt = DRAIN;
            DRAIN:   if (r == PCNT) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q     <= '0;
            r     <= '0;
            tgt_r <= '0;
            err   <= 1'b0;
            rd_re <= '0;
            rd_im <= '0;
            for (int k = 0; k < D; k++) begin
                mem_re[k] <= '0;
                mem_im[k] <= '0;
            end
        end else begin
            err <= start_bad;
            if (start_ok) begin
                tgt_r <= tgt;
                q     <= '0;
                r     <= '0;
            end
            if (xfer) q <= q + ONE;
            // Pairs are disjoint, so a retire never touches the pair being issued.
            if (ret) begin
                r           <= r + ONE;
                mem_re[i0r] <= r0_re;
                mem_im[i0r] <= r0_im;
                mem_re[i1r] <= r1_re;
                mem_im[i1r] <= r1_im;
            end
            if ((state == IDLE) && ld_en) begin
                mem_re[ld_addr] <= ld_re;
                mem_im[ld_addr] <= ld_im;
                rd_re           <= ld_re;
                rd_im           <= ld_im;
            end else begin
                rd_re <= mem_re[ld_addr];
                rd_im <= mem_im[ld_addr];
            end
        end
    end

`ifdef SWEEP_STATS_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk) begin
        if (rst)
            stall_q <= '0;
        else if (start_ok)
            stall_q <= '0;
        else if (pair_valid && !pair_ready && (stall_q != 16'hFFFF))
            stall_q <= stall_q + 16'd1;
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_amp_pair_sequencer.sv
// Bench for amp_pair_sequencer: acts as host and CAU, compares against an index-enumerating
// reference model of the state vector.
module tb_amp_pair_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        ld_en;
    logic [2:0]  ld_addr;
    logic [15:0] ld_re, ld_im, rd_re, rd_im;
    logic        start;
    logic [1:0]  tgt;
    logic        busy, done, err, pair_valid, pair_ready, res_valid, res_ready;
    logic [15:0] a0_re, a0_im, a1_re, a1_im;
    logic [1:0]  pair_idx;
    logic [15:0] r0_re, r0_im, r1_re, r1_im, stall_cnt;

    logic [15:0] mod_re [8];
    logic [15:0] mod_im [8];
    int total = 0;
    int bad   = 0;

    amp_pair_sequencer #(.N(3), .W(16)) dut (
        .clk(clk), .rst(rst), .ld_en(ld_en), .ld_addr(ld_addr), .ld_re(ld_re), .ld_im(ld_im),
        .rd_re(rd_re), .rd_im(rd_im), .start(start), .tgt(tgt), .busy(busy), .done(done),
        .err(err), .pair_valid(pair_valid), .pair_ready(pair_ready), .a0_re(a0_re),
        .a0_im(a0_im), .a1_re(a1_re), .a1_im(a1_im), .pair_idx(pair_idx),
        .res_valid(res_valid), .res_ready(res_ready), .r0_re(r0_re), .r0_im(r0_im),
        .r1_re(r1_re), .r1_im(r1_im), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic load(input bit ramp);
        for (int k = 0; k < 8; k++) begin
            ld_en   = 1'b1;
            ld_addr = 3'(k);
            ld_re   = ramp ? 16'(k)  : 16'($urandom);
            ld_im   = ramp ? 16'(-k) : 16'($urandom);
            mod_re[k] = ld_re;
            mod_im[k] = ld_im;
            @(negedge clk);
            chk("load_rd_re", rd_re, mod_re[k]);
            chk("load_rd_im", rd_im, mod_im[k]);
        end
        ld_en = 1'b0;
    endtask

    task automatic readback(input string tag);
        for (int k = 0; k < 8; k++) begin
            ld_addr = 3'(k);
            @(negedge clk);
            chk({tag, "_re"}, rd_re, mod_re[k]);
            chk({tag, "_im"}, rd_im, mod_im[k]);
        end
    endtask

    // mode 0: CAU swaps the pair; mode 1: CAU returns random data.
    task automatic sweep(input int t, input int rp, input int vp, input int mode,
                         input int stall_at, input bit delay_res);
        int lo[$];
        int q0[$];
        int q1[$];
        int issued = 0, retired = 0, stalls = 0, held = 0, cyc = 0, post = 0;
        int e0, e1;
        logic pr, rv, exp_rr;
        logic [15:0] xr0, xi0, xr1, xi1;
        for (int i = 0; i < 8; i++)
            if (((i >> t) & 1) == 0) lo.push_back(i);
        @(negedge clk);
        start = 1'b1;
        tgt   = 2'(t);
        @(negedge clk);
        start = 1'b0;
        while (1) begin
            if (cyc > 2000) begin
                chk("sweep_timeout_done", done, 1);
                break;
            end
            if (done) begin
                chk("done_after_all_results", 32'(retired), 4);
                break;
            end
            chk("busy_in_sweep", busy, 1);
            chk("pair_valid", pair_valid, issued < 4);
            exp_rr = retired < issued;
            chk("res_ready", res_ready, exp_rr);
            if (issued < 4) begin
                e0 = lo[issued];
                e1 = e0 + (1 << t);
                chk("a0_re", a0_re, mod_re[e0]);
                chk("a0_im", a0_im, mod_im[e0]);
                chk("a1_re", a1_re, mod_re[e1]);
                chk("a1_im", a1_im, mod_im[e1]);
                chk("pair_idx", pair_idx, 32'(issued));
            end
            if (stall_at >= 0 && issued == stall_at && held < 3) begin
                pr = 1'b0;
                held++;
            end else begin
                pr = ($urandom_range(99) < rp);
            end
            rv = delay_res ? (issued == 4 && post >= 5) : ($urandom_range(99) < vp);
            xr0 = 16'($urandom); xi0 = 16'($urandom);
            xr1 = 16'($urandom); xi1 = 16'($urandom);
            if (rv && exp_rr && mode == 0) begin
                xr0 = mod_re[q1[0]]; xi0 = mod_im[q1[0]];
                xr1 = mod_re[q0[0]]; xi1 = mod_im[q0[0]];
            end
            pair_ready = pr;
            res_valid  = rv;
            r0_re = xr0; r0_im = xi0; r1_re = xr1; r1_im = xi1;
            start   = ($urandom_range(7) == 0);
            tgt     = 2'($urandom);
            ld_en   = ($urandom_range(3) == 0);
            ld_addr = 3'($urandom);
            ld_re   = 16'($urandom);
            ld_im   = 16'($urandom);
            if (issued < 4 && !pr) stalls++;
            if (issued < 4 && pr) begin
                q0.push_back(lo[issued]);
                q1.push_back(lo[issued] + (1 << t));
                issued++;
            end
            if (rv && exp_rr) begin
                e0 = q0.pop_front();
                e1 = q1.pop_front();
                mod_re[e0] = xr0; mod_im[e0] = xi0;
                mod_re[e1] = xr1; mod_im[e1] = xi1;
                retired++;
            end
            @(negedge clk);
            cyc++;
            if (issued == 4) post++;
        end
        start = 1'b0; ld_en = 1'b0; res_valid = 1'b0; pair_ready = 1'b0;
`ifdef SWEEP_STATS_EN
        chk("stall_cnt", stall_cnt, 32'(stalls));
`else
        chk("stall_cnt", stall_cnt, 0);
`endif
        @(negedge clk);
        chk("done_one_cycle", done, 0);
        chk("busy_after_done", busy, 0);
        res_valid = 1'b1;
        r0_re = 16'h5A5A; r0_im = 16'hA5A5; r1_re = 16'h1234; r1_im = 16'h4321;
        chk("spurious_res_ready", res_ready, 0);
        @(negedge clk);
        res_valid = 1'b0;
        readback("mem_after_sweep");
    endtask

    initial begin
        rst = 1'b1; ld_en = 1'b0; ld_addr = '0; ld_re = '0; ld_im = '0;
        start = 1'b0; tgt = '0; pair_ready = 1'b0; res_valid = 1'b0;
        r0_re = '0; r0_im = '0; r1_re = '0; r1_im = '0;
        for (int k = 0; k < 8; k++) begin
            mod_re[k] = '0;
            mod_im[k] = '0;
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_pair_valid", pair_valid, 0);
        chk("rst_res_ready", res_ready, 0);
        chk("rst_a0_re", a0_re, 0);
        chk("rst_rd_re", rd_re, 0);
        chk("rst_stall_cnt", stall_cnt, 0);
        readback("rst_mem");

        load(1'b1);
        sweep(0, 100, 100, 0, -1, 1'b0);
        ld_addr = 3'd0;
        @(negedge clk);
        chk("tgt0_mem0_re", rd_re, 16'd1);
        chk("tgt0_mem0_im", rd_im, 16'hFFFF);
        ld_addr = 3'd1;
        @(negedge clk);
        chk("tgt0_mem1_re", rd_re, 16'd0);
        chk("tgt0_mem1_im", rd_im, 16'd0);

        load(1'b1);
        sweep(2, 100, 100, 0, -1, 1'b0);

        load(1'b1);
        sweep(1, 100, 100, 0, 1, 1'b0);

        load(1'b1);
        sweep(0, 100, 0, 0, -1, 1'b1);

        @(negedge clk);
        start = 1'b1;
        tgt   = 2'd3;
        @(negedge clk);
        start = 1'b0;
        chk("err_pulse", err, 1);
        chk("err_busy", busy, 0);
        @(negedge clk);
        chk("err_one_cycle", err, 0);
        chk("err_busy_later", busy, 0);

        for (int it = 0; it < 6; it++) begin
            load(1'b0);
            sweep($urandom_range(2), $urandom_range(100, 30), $urandom_range(100, 30), 1, -1, 1'b0);
        end

        load(1'b0);
        @(negedge clk);
        start = 1'b1;
        tgt   = 2'd1;
        @(negedge clk);
        start      = 1'b0;
        pair_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        pair_ready = 1'b0;
        rst        = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            mod_re[k] = '0;
            mod_im[k] = '0;
        end
        chk("midrst_busy", busy, 0);
        chk("midrst_pair_valid", pair_valid, 0);
        chk("midrst_res_ready", res_ready, 0);
        chk("midrst_a1_im", a1_im, 0);
        chk("midrst_pair_idx", pair_idx, 0);
        chk("midrst_stall_cnt", stall_cnt, 0);
        chk("midrst_rd_re", rd_re, 0);
        for (int k = 0; k < 3; k++) begin
            chk("midrst_no_done", done, 0);
            @(negedge clk);
        end
        readback("midrst_mem");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
